// File: rtl/ledr_anim_ctrl_if.sv
// Interface bundling the game-side LED patterns, outcome events and the
// board-side LED drive/mode outputs of the LEDR animation controller.
interface ledr_anim_ctrl_if #(
    parameter int LED_W = 18
);
    logic [LED_W-1:0] leds_vitoria;
    logic [LED_W-1:0] leds_derrota;
    logic [LED_W-1:0] leds_dica;
    logic             senha_correta;
    logic             derrota;
    logic             novo_jogo;
    logic [LED_W-1:0] LEDR;
    logic [1:0]       estado;

    // The game FSM side: drives patterns and events, observes LEDs and mode
    modport master (
        output leds_vitoria, leds_derrota, leds_dica,
        output senha_correta, derrota, novo_jogo,
        input  LEDR, estado
    );

    // The controller side: consumes patterns and events, drives LEDs and mode
    modport slave (
        input  leds_vitoria, leds_derrota, leds_dica,
        input  senha_correta, derrota, novo_jogo,
        output LEDR, estado
    );
endinterface

// File: rtl/ledr_anim_ctrl.sv
// LEDR animation controller for the password game.
// Latches the game outcome and animates the selected pattern:
// hint mode passes leds_dica through, victory blinks leds_vitoria and
// defeat rotates leds_derrota left, one step per animation tick.
module ledr_anim_ctrl #(
    parameter int LED_W    = 18,
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    ledr_anim_ctrl_if.slave        bus
);
    localparam int ROT_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(LED_W - 1);

    typedef enum logic [1:0] {
        DICA    = 2'b00,
        VITORIA = 2'b01,
        DERROTA = 2'b10
    } mode_e;

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic [LED_W-1:0] ledr_q, ledr_d;
    logic [LED_W-1:0] rotated;
    logic             tick;

    assign tick       = (cnt_q == CNT_LAST);
    assign bus.LEDR   = ledr_q;
    assign bus.estado = state_q;

    // Mode selection: novo_jogo always wins, outcomes are sticky until then
    always_comb begin
        state_d = state_q;
        if (bus.novo_jogo) begin
            state_d = DICA;
        end else begin
            case (state_q)
                DICA: begin
                    if (bus.senha_correta) begin
                        state_d = VITORIA;
                    end else if (bus.derrota) begin
                        state_d = DERROTA;
                    end
                end
                VITORIA, DERROTA: state_d = state_q;
                default:          state_d = DICA;
            endcase
        end
    end

    // Prescaler and animation step; any mode entry restarts a full-length first step
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        rot_d   = rot_q;
        if (bus.novo_jogo || (state_d != state_q)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
            rot_d   = '0;
        end else if (state_q == DICA) begin
            cnt_d = '0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                if (state_q == VITORIA) begin
                    phase_d = ~phase_q;
                end else if (state_q == DERROTA) begin
                    rot_d = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
                end
            end
        end
    end

    // Pattern selection from the registered mode and live pattern inputs
    always_comb begin
        rotated = (bus.leds_derrota << rot_q)
                | (bus.leds_derrota >> (LED_W - int'(rot_q)));
        ledr_d  = '0;
        case (state_q)
            DICA:    ledr_d = bus.leds_dica;
            VITORIA: ledr_d = phase_q ? bus.leds_vitoria : '0;
            DERROTA: ledr_d = rotated;
            default: ledr_d = '0;
        endcase
    end

    // State, animation and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DICA;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            rot_q   <= '0;
            ledr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rot_q   <= rot_d;
            ledr_q  <= ledr_d;
        end
    end
endmodule

// File: tb/tb_ledr_anim_ctrl.sv
// Self-checking bench for ledr_anim_ctrl with a behavioural model of the
// LED animation, directed scenarios and a randomized stretch.
module tb_ledr_anim_ctrl;
    localparam int LED_W    = 18;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ledr_anim_ctrl_if #(.LED_W(LED_W)) bus ();

    ledr_anim_ctrl #(
        .LED_W(LED_W),
        .TICK_DIV(TICK_DIV),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: mMode follows the estado encoding (DICA, VITORIA, DERROTA), age = edges since mode entry
    int               mMode  = 0;
    int               mAge   = 0;
    logic [LED_W-1:0] mLedr  = '0;
    bit               mValid = 1'b0;

    function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v, input int r);
        logic [LED_W-1:0] o;
        o = '0;
        for (int i = 0; i < LED_W; i++) begin
            o[(i + r) % LED_W] = v[i];
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic sc, input logic de,
                                 input logic nj, input logic [LED_W-1:0] vit,
                                 input logic [LED_W-1:0] der, input logic [LED_W-1:0] dica);
        rst               = r;
        bus.senha_correta = sc;
        bus.derrota       = de;
        bus.novo_jogo     = nj;
        bus.leds_vitoria  = vit;
        bus.leds_derrota  = der;
        bus.leds_dica     = dica;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: animation step number is age / TICK_DIV
    always @(posedge clk) begin : model
        int               stepNo;
        int               nextMode;
        logic [LED_W-1:0] nextLedr;
        if (rst) begin
            mMode  = 0;
            mAge   = 0;
            mLedr  = '0;
            mValid = 1'b1;
        end else if (mValid) begin
            stepNo = mAge / TICK_DIV;
            case (mMode)
                0:       nextLedr = bus.leds_dica;
                1:       nextLedr = (stepNo % 2 == 0) ? bus.leds_vitoria : '0;
                default: nextLedr = rotl(bus.leds_derrota, stepNo % LED_W);
            endcase
            if (bus.novo_jogo)          nextMode = 0;
            else if (mMode != 0)        nextMode = mMode;
            else if (bus.senha_correta) nextMode = 1;
            else if (bus.derrota)       nextMode = 2;
            else                        nextMode = 0;
            if (bus.novo_jogo || nextMode != mMode) mAge = 0;
            else if (mMode != 0)                    mAge = mAge + 1;
            mMode = nextMode;
            mLedr = nextLedr;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model_LEDR", 32'(bus.LEDR), 32'(mLedr));
            checkOutput("model_estado", 32'(bus.estado), 32'(mMode));
        end
    end

    initial begin
        // Reset then hint pass-through
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        step(2);
        checkOutput("reset_LEDR", 32'(bus.LEDR), 32'h0);
        checkOutput("reset_estado", 32'(bus.estado), 32'h0);
        applyStimulus(0, 0, 0, 0, '0, '0, 18'h00A5A);
        step(2);
        checkOutput("hint_LEDR", 32'(bus.LEDR), 32'h00A5A);
        checkOutput("hint_estado", 32'(bus.estado), 32'h0);

        // Victory blink, then an ignored defeat pulse
        applyStimulus(0, 1, 0, 0, 18'h3FFFF, '0, 18'h00A5A);
        step(1);
        applyStimulus(0, 0, 0, 0, 18'h3FFFF, '0, 18'h00A5A);
        checkOutput("vit_estado", 32'(bus.estado), 32'h1);
        step(1);
        checkOutput("vit_on_first", 32'(bus.LEDR), 32'h3FFFF);
        step(3);
        checkOutput("vit_on_last", 32'(bus.LEDR), 32'h3FFFF);
        step(1);
        checkOutput("vit_off_first", 32'(bus.LEDR), 32'h0);
        step(3);
        checkOutput("vit_off_last", 32'(bus.LEDR), 32'h0);
        step(1);
        checkOutput("vit_on_again", 32'(bus.LEDR), 32'h3FFFF);
        applyStimulus(0, 0, 1, 0, 18'h3FFFF, '0, 18'h00A5A);
        step(1);
        applyStimulus(0, 0, 0, 0, 18'h3FFFF, '0, 18'h00A5A);
        step(1);
        checkOutput("vit_sticky", 32'(bus.estado), 32'h1);

        // Randomized stretch checked by the model
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 79) == 0),
                          LED_W'($urandom), LED_W'($urandom), LED_W'($urandom));
            step(1);
        end

        // Defeat rotation and wrap
        applyStimulus(0, 0, 0, 1, '0, 18'h00001, 18'h00A5A);
        step(1);
        applyStimulus(0, 0, 1, 0, '0, 18'h00001, 18'h00A5A);
        step(1);
        applyStimulus(0, 0, 0, 0, '0, 18'h00001, 18'h00A5A);
        step(1);
        checkOutput("der_rot0", 32'(bus.LEDR), 32'h00001);
        checkOutput("der_estado", 32'(bus.estado), 32'h2);
        step(4);
        checkOutput("der_rot1", 32'(bus.LEDR), 32'h00002);
        step(64);
        checkOutput("der_rot17", 32'(bus.LEDR), 32'h20000);
        step(4);
        checkOutput("der_wrap", 32'(bus.LEDR), 32'h00001);

        // novo_jogo priority at rot=5, then a fresh unrotated defeat
        applyStimulus(0, 0, 0, 1, '0, 18'h00001, 18'h12345);
        step(1);
        applyStimulus(0, 0, 1, 0, '0, 18'h00001, 18'h12345);
        step(1);
        applyStimulus(0, 0, 0, 0, '0, 18'h00001, 18'h12345);
        step(21);
        checkOutput("der_rot5", 32'(bus.LEDR), 32'h00020);
        applyStimulus(0, 1, 0, 1, '0, 18'h00001, 18'h12345);
        step(1);
        applyStimulus(0, 0, 0, 0, '0, 18'h00001, 18'h12345);
        checkOutput("novo_estado", 32'(bus.estado), 32'h0);
        step(1);
        checkOutput("novo_LEDR", 32'(bus.LEDR), 32'h12345);
        applyStimulus(0, 0, 1, 0, '0, 18'h00003, 18'h12345);
        step(1);
        applyStimulus(0, 0, 0, 0, '0, 18'h00003, 18'h12345);
        step(1);
        checkOutput("restart_unrot", 32'(bus.LEDR), 32'h00003);

        // Simultaneous events from hint mode favour victory
        applyStimulus(0, 0, 0, 1, 18'h15555, '0, 18'h12345);
        step(1);
        applyStimulus(0, 1, 1, 0, 18'h15555, '0, 18'h12345);
        step(1);
        applyStimulus(0, 0, 0, 0, 18'h15555, '0, 18'h12345);
        checkOutput("both_estado", 32'(bus.estado), 32'h1);

        // Reset while the victory blink is in its dark phase
        step(5);
        checkOutput("vit_dark", 32'(bus.LEDR), 32'h0);
        applyStimulus(1, 0, 0, 0, 18'h15555, '0, 18'h2B0C1);
        step(1);
        checkOutput("midrst_estado", 32'(bus.estado), 32'h0);
        checkOutput("midrst_LEDR", 32'(bus.LEDR), 32'h0);
        applyStimulus(0, 0, 0, 0, 18'h15555, '0, 18'h2B0C1);
        step(1);
        checkOutput("postrst_LEDR", 32'(bus.LEDR), 32'h2B0C1);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
